// File: rtl/dcache_2way.sv
// 2-way set-associative, write-through, no-write-allocate data cache with per-set LRU,
// a handshaked memory port, flush and hit/miss counters.
module dcache_2way #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned SETS  = 2 ** INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {StIdle, StFill, StWbusy} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]   valid0_q, valid1_q, lru_q;
  logic [TAG_W-1:0]  tag0_q  [SETS];
  logic [TAG_W-1:0]  tag1_q  [SETS];
  logic [DATA_W-1:0] data0_q [SETS];
  logic [DATA_W-1:0] data1_q [SETS];

  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Lookup uses the live CPU address; fills use the address latched on the miss.
  logic [INDEX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit0, hit1, hit, victim;
  logic [DATA_W-1:0]  hit_data;

  assign req_idx  = cpu_addr[INDEX_W-1:0];
  assign req_tag  = cpu_addr[ADDR_W-1:INDEX_W];
  assign fill_idx = mem_addr_q[INDEX_W-1:0];
  assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_W];

  assign hit0     = valid0_q[req_idx] && (tag0_q[req_idx] == req_tag);
  assign hit1     = valid1_q[req_idx] && (tag1_q[req_idx] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_data = hit0 ? data0_q[req_idx] : data1_q[req_idx];
  assign victim   = !valid0_q[fill_idx] ? 1'b0 :
                    !valid1_q[fill_idx] ? 1'b1 : lru_q[fill_idx];

  // Array write controls
  logic               wr0, wr1, wr_fill, lru_we, lru_val, flush_all;
  logic [INDEX_W-1:0] wr_idx, lru_idx;
  logic [DATA_W-1:0]  wr_data;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wr0          = 1'b0;
    wr1          = 1'b0;
    wr_fill      = 1'b0;
    wr_idx       = req_idx;
    wr_data      = cpu_wdata;
    lru_we       = 1'b0;
    lru_idx      = req_idx;
    lru_val      = 1'b0;
    flush_all    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush) begin
          flush_all = 1'b1;
        end else if (cpu_req) begin
          if (hit) begin
            hit_count_d = hit_count_q + CNT_W'(1);
            lru_we      = 1'b1;
            lru_val     = hit0;  // evict the way that was not just used
          end else begin
            miss_count_d = miss_count_q + CNT_W'(1);
          end
          if (cpu_we) begin
            wr0         = hit0;
            wr1         = hit1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            state_d     = StWbusy;
          end else if (hit) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = hit_data;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = cpu_addr;
            state_d    = StFill;
          end
        end
      end
      StFill: begin
        if (mem_ack) begin
          wr0         = ~victim;
          wr1         = victim;
          wr_fill     = 1'b1;
          wr_idx      = fill_idx;
          wr_data     = mem_rdata;
          lru_we      = 1'b1;
          lru_idx     = fill_idx;
          lru_val     = ~victim;
          mem_req_d   = 1'b0;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = mem_rdata;
          state_d     = StIdle;
        end
      end
      StWbusy: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      if (flush_all) begin
        valid0_q <= '0;
        valid1_q <= '0;
      end else if (wr_fill) begin
        if (wr0) valid0_q[wr_idx] <= 1'b1;
        if (wr1) valid1_q[wr_idx] <= 1'b1;
      end
      if (lru_we) lru_q[lru_idx] <= lru_val;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wr0) data0_q[wr_idx] <= wr_data;
      if (wr1) data1_q[wr_idx] <= wr_data;
      if (wr0 && wr_fill) tag0_q[wr_idx] <= fill_tag;
      if (wr1 && wr_fill) tag1_q[wr_idx] <= fill_tag;
    end
  end

  assign cpu_busy   = (state_q != StIdle);
  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_2way.sv
// Bench for dcache_2way: directed scenarios plus random traffic checked every cycle against
// a recency-list cache model and a reference memory image.
module tb_dcache_2way;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int INDEX_W = 6;
  localparam int CNT_W   = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, flush;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_ready, cpu_busy;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  hit_count, miss_count;

  always #5 clock = ~clock;

  dcache_2way #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_busy  (cpu_busy),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory (served to the DUT) and the reference image the model predicts from.
  logic [DATA_W-1:0] mem_arr [65536];
  logic [DATA_W-1:0] ref_mem [65536];

  // Memory responder
  int ack_delay = 3;
  bit rand_mode = 1'b0;
  int wait_cnt  = 0;

  function automatic int next_delay();
    return rand_mode ? int'($urandom_range(3)) : ack_delay;
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ack   = 1'b0;
      mem_rdata = DATA_W'($urandom);
      if (mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_arr[mem_addr];
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          wait_cnt = next_delay();
        end else begin
          wait_cnt--;
        end
      end else begin
        wait_cnt = next_delay();
        if (rand_mode && $urandom_range(7) == 0) mem_ack = 1'b1;  // stray ack, must be ignored
      end
    end
  end

  // Cache model: per set, resident line addresses ordered most- to least-recently used.
  int                res_n [64];
  logic [ADDR_W-1:0] res_a [64][2];

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) res_n[s] = 0;
  endfunction

  function automatic bit m_lookup(input logic [ADDR_W-1:0] a);
    int s = int'(a[INDEX_W-1:0]);
    for (int i = 0; i < res_n[s]; i++) if (res_a[s][i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_touch(input logic [ADDR_W-1:0] a);
    int s = int'(a[INDEX_W-1:0]);
    if (res_n[s] == 2 && res_a[s][1] == a) begin
      res_a[s][1] = res_a[s][0];
      res_a[s][0] = a;
    end
  endfunction

  function automatic void m_insert(input logic [ADDR_W-1:0] a);
    int s = int'(a[INDEX_W-1:0]);
    res_a[s][1] = res_a[s][0];
    res_a[s][0] = a;
    if (res_n[s] < 2) res_n[s]++;
  endfunction

  // Compare process: sampled just after each rising edge, inputs are those that edge used.
  bit                m_busy = 1'b0, m_store = 1'b0, m_hit, e_ready;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, e_rdata = '0;
  logic [CNT_W-1:0]  e_hits = '0, e_miss = '0;

  initial begin
    m_clear();
    forever begin
      @(posedge clock);
      #1;
      e_ready = 1'b0;
      if (reset) begin
        m_clear();
        m_busy  = 1'b0;
        m_store = 1'b0;
        e_rdata = '0;
        e_hits  = '0;
        e_miss  = '0;
      end else if (!m_busy) begin
        if (flush) begin
          m_clear();
        end else if (cpu_req) begin
          m_hit = m_lookup(cpu_addr);
          if (m_hit) begin
            e_hits++;
            m_touch(cpu_addr);
          end else begin
            e_miss++;
          end
          if (cpu_we) begin
            ref_mem[cpu_addr] = cpu_wdata;
            m_busy  = 1'b1;
            m_store = 1'b1;
            m_addr  = cpu_addr;
            m_wdata = cpu_wdata;
          end else if (m_hit) begin
            e_ready = 1'b1;
            e_rdata = ref_mem[cpu_addr];
          end else begin
            m_busy  = 1'b1;
            m_store = 1'b0;
            m_addr  = cpu_addr;
          end
        end
      end else if (mem_ack) begin
        if (!m_store) begin
          m_insert(m_addr);
          e_rdata = ref_mem[m_addr];
        end
        e_ready = 1'b1;
        m_busy  = 1'b0;
      end

      check("cpu_ready", 32'(cpu_ready), 32'(e_ready));
      check("cpu_busy", 32'(cpu_busy), 32'(m_busy));
      check("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
      check("hit_count", 32'(hit_count), 32'(e_hits));
      check("miss_count", 32'(miss_count), 32'(e_miss));
      check("mem_req", 32'(mem_req), 32'(m_busy));
      check("mem_we", 32'(mem_we), 32'(m_busy && m_store));
      if (m_busy) begin
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_store) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
    end
  end

  // Issue one access at a negedge with cpu_busy=0; returns at the negedge showing cpu_ready.
  task automatic access(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit noise, output int lat);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    @(negedge clock);
    cpu_req = 1'b0;
    lat     = 1;
    while (!cpu_ready && lat < 200) begin
      if (noise) flush = ($urandom_range(3) == 0);  // flush while busy must be ignored
      @(negedge clock);
      lat++;
    end
    flush = 1'b0;
    if (!cpu_ready) check("access_timeout", 32'(lat), 32'd0);
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = DATA_W'(i * 7) ^ 16'h5A5A;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[16'h0040] = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; flush = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_memreq", 32'(mem_req), 32'd0);

    // Cold load miss, memory answers after 3 wait cycles
    access(1'b0, 16'h0040, '0, 1'b0, lat);
    check("miss_lat", 32'(lat), 32'd5);
    check("miss_rdata", 32'(cpu_rdata), 32'hBEEF);
    check("miss_cnt1", 32'(miss_count), 32'd1);
    access(1'b0, 16'h0040, '0, 1'b0, lat);
    check("hit_lat", 32'(lat), 32'd1);
    check("hit_rdata", 32'(cpu_rdata), 32'hBEEF);
    check("hit_cnt1", 32'(hit_count), 32'd1);

    // Three tags in set 0: 0x0000 ends up LRU and is evicted by 0x0080
    access(1'b0, 16'h0000, '0, 1'b0, lat);
    access(1'b0, 16'h0040, '0, 1'b0, lat);
    access(1'b0, 16'h0080, '0, 1'b0, lat);
    access(1'b0, 16'h0040, '0, 1'b0, lat);
    check("conflict_keep_hit", 32'(lat), 32'd1);
    access(1'b0, 16'h0000, '0, 1'b0, lat);
    check("conflict_evicted", 32'(lat > 1), 32'd1);
    check("conflict_hits", 32'(hit_count), 32'd3);
    check("conflict_miss", 32'(miss_count), 32'd4);

    // Store hit then load sees new data
    access(1'b1, 16'h0040, 16'h1234, 1'b0, lat);
    access(1'b0, 16'h0040, '0, 1'b0, lat);
    check("store_hit_lat", 32'(lat), 32'd1);
    check("store_hit_rdata", 32'(cpu_rdata), 32'h1234);
    check("store_hit_cnt", 32'(hit_count), 32'd5);

    // Store miss does not allocate
    access(1'b1, 16'h0100, 16'hCAFE, 1'b0, lat);
    check("store_miss_cnt", 32'(miss_count), 32'd5);
    access(1'b0, 16'h0100, '0, 1'b0, lat);
    check("no_alloc_miss", 32'(miss_count), 32'd6);
    check("no_alloc_rdata", 32'(cpu_rdata), 32'hCAFE);

    // Flush, with a simultaneous request that must be dropped
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    @(negedge clock);
    flush = 1'b0; cpu_req = 1'b0;
    check("flush_no_ready", 32'(cpu_ready), 32'd0);
    access(1'b0, 16'h0040, '0, 1'b0, lat);
    check("flush_miss", 32'(miss_count), 32'd7);

    // Reset in the middle of a fill
    ack_delay = 1000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00C0;
    @(negedge clock);
    cpu_req = 1'b0;
    check("fill_busy", 32'(cpu_busy), 32'd1);
    ack_delay = 2;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_memreq", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(cpu_busy), 32'd0);
    check("midrst_hits", 32'(hit_count), 32'd0);
    check("midrst_miss", 32'(miss_count), 32'd0);
    access(1'b0, 16'h0040, '0, 1'b0, lat);
    check("midrst_reload_miss", 32'(miss_count), 32'd1);
    check("midrst_reload_rdata", 32'(cpu_rdata), 32'h1234);

    // Random traffic over a handful of sets and tags
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(($urandom_range(5) << INDEX_W) | $urandom_range(3));
      if ($urandom_range(19) == 0) begin
        flush = 1'b1; cpu_req = $urandom_range(1) == 1; cpu_we = 1'b0; cpu_addr = a;
        @(negedge clock);
        flush = 1'b0; cpu_req = 1'b0;
      end else begin
        access($urandom_range(9) < 4, a, DATA_W'($urandom), 1'b1, lat);
      end
    end
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
